arrow_wave_sequencer: RTL

//  Parametrised enemy-turn sequencer for the bullet-box phase. Walks a pattern step table
//  one step at a time and spawns arrows into NUM_LANES arrow lanes with per-step delay,

---
 rtl/enemy_pkg.sv | 39 +++
 rtl/hit_merger.sv | 74 +++++++
 rtl/arrow_wave_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/enemy_pkg.sv
// Shared types for the enemy-turn sequencer: FSM states, step-table record layout and arrow directions.
package enemy_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_COUNT,
    S_SPAWN,
    S_DRAIN
  } seq_state_e;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Record layout at the default widths; the sequencer slices the same order at any width.
  localparam int STEP_TIMING_W = 3;
  localparam int STEP_LANE_W   = 5;
  localparam int STEP_SPEED_W  = 4;

  typedef struct packed {
    logic [STEP_TIMING_W-1:0] timing;
    logic [STEP_LANE_W-1:0]   lane;
    logic [STEP_SPEED_W-1:0]  speed;
    logic [1:0]               dir;
    logic                     inv;
  } step_t;

  function automatic int lane_w(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  function automatic int step_w(input int timing_w, input int lane_bits, input int speed_w);
    return timing_w + lane_bits + speed_w + 3;
  endfunction

endpackage

// File: rtl/hit_merger.sv
// Merges per-lane hit levels into single damage events with a saturating per-turn count.
// ARROW_WAVE_IFRAMES_EN adds an invulnerability window after each event.
module hit_merger #(
  parameter int NUM_LANES = 24,
`ifdef ARROW_WAVE_IFRAMES_EN
  parameter int IFRAME_CYCLES = 32_500_000,
`endif
  parameter int HITCNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 busy,
  input  logic                 clear,
  input  logic                 abort,
  input  logic [NUM_LANES-1:0] hit_in,
  output logic                 damage_out,
  output logic [HITCNT_W-1:0]  hit_count_out
);

  logic [NUM_LANES-1:0] hit_prev_reg;
  logic [NUM_LANES-1:0] rise;
  logic                 event_raw;
  logic                 event_hit;
  logic                 damage_reg;
  logic [HITCNT_W-1:0]  hit_count_reg;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_edge
      assign rise[gi] = hit_in[gi] & ~hit_prev_reg[gi];
    end
  endgenerate

  // Several lanes rising together still count as one event.
  assign event_raw = busy & (|rise);

`ifdef ARROW_WAVE_IFRAMES_EN
  localparam int MASK_W = $clog2(IFRAME_CYCLES + 1);
  logic [MASK_W-1:0] mask_cnt_reg;

  assign event_hit = event_raw && (mask_cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (!rst || clear || abort) begin
      mask_cnt_reg <= '0;
    end else if (event_hit) begin
      mask_cnt_reg <= MASK_W'(IFRAME_CYCLES);
    end else if (mask_cnt_reg != '0) begin
      mask_cnt_reg <= mask_cnt_reg - MASK_W'(1);
    end
  end
`else
  assign event_hit = event_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_prev_reg  <= '0;
      damage_reg    <= 1'b0;
      hit_count_reg <= '0;
    end else begin
      hit_prev_reg <= hit_in;
      damage_reg   <= event_hit;
      if (clear) begin
        hit_count_reg <= '0;
      end else if (event_hit && (hit_count_reg != '1)) begin
        hit_count_reg <= hit_count_reg + HITCNT_W'(1);
      end
    end
  end

  assign damage_out    = damage_reg;
  assign hit_count_out = hit_count_reg;

endmodule

// File: rtl/arrow_wave_sequencer.sv
// Enemy-turn sequencer: walks the pattern step table, spawns arrows per lane, reports damage
// and completion. Optional i-frame masking is enabled by defining ARROW_WAVE_IFRAMES_EN.
module arrow_wave_sequencer
  import enemy_pkg::*;
#(
  parameter int         NUM_LANES   = 24,
  parameter int         MAX_STEPS   = 24,
  parameter int         TIMING_W    = 3,
  parameter int         SPEED_W     = 4,
  parameter int         TICK_CYCLES = 32_500_000,
  parameter logic [3:0] START_STATE = 4'b1000,
  parameter int         HITCNT_W    = 8,
  localparam int        LANE_W      = lane_w(NUM_LANES),
  localparam int        STEP_W      = step_w(TIMING_W, LANE_W, SPEED_W),
  localparam int        ADDR_W      = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           state_in,
  input  logic                 abort_in,
  output logic [ADDR_W-1:0]    step_addr_out,
  input  logic [STEP_W-1:0]    step_data_in,
  input  logic [NUM_LANES-1:0] lane_active_in,
  input  logic [NUM_LANES-1:0] hit_in,
  output logic [NUM_LANES-1:0] spawn_out,
  output logic [SPEED_W-1:0]   speed_out,
  output logic [1:0]           dir_out,
  output logic                 inv_out,
  output logic                 busy_out,
  output logic                 finished_out,
  output logic                 damage_out,
  output logic [HITCNT_W-1:0]  hit_count_out
);

  localparam int IDX_W   = $clog2(MAX_STEPS + 1);
  localparam int CNT_W   = $clog2((2**TIMING_W - 1) * TICK_CYCLES + 1);
  localparam int LANE_LO = SPEED_W + 3;
  localparam int TIM_LO  = LANE_LO + LANE_W;

  localparam logic [CNT_W-1:0]  TICK_C  = CNT_W'(TICK_CYCLES);
  localparam logic [IDX_W-1:0]  MAX_IDX = IDX_W'(MAX_STEPS);
  localparam logic [LANE_W:0]   LANES_C = (LANE_W+1)'(NUM_LANES);

  logic [TIMING_W-1:0] step_timing;
  logic [LANE_W-1:0]   step_lane;
  logic [SPEED_W-1:0]  step_speed;
  logic [1:0]          step_dir;
  logic                step_inv;

  assign step_timing = step_data_in[STEP_W-1:TIM_LO];
  assign step_lane   = step_data_in[TIM_LO-1:LANE_LO];
  assign step_speed  = step_data_in[LANE_LO-1:3];
  assign step_dir    = step_data_in[2:1];
  assign step_inv    = step_data_in[0];

  seq_state_e          state_reg;
  logic [3:0]          state_in_prev_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    cnt_target_reg;
  logic [LANE_W-1:0]   lane_reg;
  logic [SPEED_W-1:0]  step_speed_reg;
  logic [1:0]          step_dir_reg;
  logic                step_inv_reg;
  logic [NUM_LANES-1:0] spawn_reg;
  logic [SPEED_W-1:0]  speed_reg;
  logic [1:0]          dir_reg;
  logic                inv_reg;
  logic                finished_reg;
  logic                start_pulse;
  logic                busy;

  assign start_pulse = (state_reg == S_IDLE) && (state_in == START_STATE) &&
                       (state_in_prev_reg != START_STATE);
  assign busy        = (state_reg != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= S_IDLE;
      state_in_prev_reg <= '0;
      idx_reg           <= '0;
      cnt_reg           <= '0;
      cnt_target_reg    <= '0;
      lane_reg          <= '0;
      step_speed_reg    <= '0;
      step_dir_reg      <= '0;
      step_inv_reg      <= 1'b0;
      spawn_reg         <= '0;
      speed_reg         <= '0;
      dir_reg           <= '0;
      inv_reg           <= 1'b0;
      finished_reg      <= 1'b0;
    end else begin
      state_in_prev_reg <= state_in;
      spawn_reg         <= '0;
      finished_reg      <= 1'b0;
      // Abort beats any spawn or finish that would otherwise happen this cycle.
      if (abort_in && busy) begin
        state_reg <= S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start_pulse) begin
              idx_reg   <= '0;
              state_reg <= S_FETCH;
            end
          end
          S_FETCH: state_reg <= S_WAIT;
          S_WAIT: begin
            if ((step_timing == '0) || (idx_reg == MAX_IDX)) begin
              state_reg <= S_DRAIN;
            end else begin
              cnt_reg        <= CNT_W'(1);
              cnt_target_reg <= CNT_W'(step_timing) * TICK_C;
              lane_reg       <= step_lane;
              step_speed_reg <= step_speed;
              step_dir_reg   <= step_dir;
              step_inv_reg   <= step_inv;
              state_reg      <= S_COUNT;
            end
          end
          S_COUNT: begin
            if (cnt_reg >= cnt_target_reg) begin
              state_reg <= S_SPAWN;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          S_SPAWN: begin
            // Out-of-range lanes are skipped; an occupied lane stalls here.
            if ({1'b0, lane_reg} >= LANES_C) begin
              idx_reg   <= idx_reg + IDX_W'(1);
              state_reg <= S_FETCH;
            end else if (!lane_active_in[lane_reg]) begin
              spawn_reg <= NUM_LANES'(1) << lane_reg;
              speed_reg <= step_speed_reg;
              dir_reg   <= step_dir_reg;
              inv_reg   <= step_inv_reg;
              idx_reg   <= idx_reg + IDX_W'(1);
              state_reg <= S_FETCH;
            end
          end
          S_DRAIN: begin
            if (lane_active_in == '0) begin
              finished_reg <= 1'b1;
              state_reg    <= S_IDLE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  hit_merger #(
    .NUM_LANES     (NUM_LANES),
`ifdef ARROW_WAVE_IFRAMES_EN
    .IFRAME_CYCLES (TICK_CYCLES),
`endif
    .HITCNT_W      (HITCNT_W)
  ) u_hit_merger (
    .clk           (clk),
    .rst           (rst),
    .busy          (busy),
    .clear         (start_pulse),
    .abort         (abort_in),
    .hit_in        (hit_in),
    .damage_out    (damage_out),
    .hit_count_out (hit_count_out)
  );

  assign step_addr_out = idx_reg[ADDR_W-1:0];
  assign spawn_out     = spawn_reg;
  assign speed_out     = speed_reg;
  assign dir_out       = dir_reg;
  assign inv_out       = inv_reg;
  assign busy_out      = busy;
  assign finished_out  = finished_reg;

endmodule
